// File: rtl/bus_hub.sv
// Host write fan-out plus per-channel one-entry readback slots drained round-robin into one output register.
// Optional BUS_HUB_DROP_CNT_EN enables the saturating dropped-request counter on drop_cnt.
module bus_hub #(
  parameter int CHANNELS = 6,
  parameter int DATA_W   = 28,
  parameter int WR_W     = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_wr,
  input  logic [3:0]                 in_addr,
  input  logic [WR_W-1:0]            in_data,
  output logic [CHANNELS-1:0]        ch_wr,
  output logic [WR_W-1:0]            ch_data,
  output logic                       unmapped,
  input  logic [CHANNELS-1:0]        rb_req,
  input  logic [CHANNELS*DATA_W-1:0] rb_data,
  output logic [CHANNELS-1:0]        rb_busy,
  output logic [DATA_W-1:0]          out_data,
  output logic [3:0]                 out_addr,
  output logic                       out_stb,
  input  logic                       out_rdy,
  output logic [7:0]                 drop_cnt
);

  localparam logic [3:0] CH_LIMIT = 4'(CHANNELS);
  localparam logic [3:0] LAST_CH  = 4'(CHANNELS - 1);

  logic [DATA_W-1:0] slot_data [CHANNELS];
  logic [CHANNELS-1:0] busy;
  logic [3:0]        last_grant;
  logic              load;
  logic              found;
  logic [3:0]        grant_idx;
  logic [DATA_W-1:0] grant_data;
  int unsigned       idx;

  assign rb_busy = busy;
  assign load    = !out_stb || out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_wr    <= '0;
      unmapped <= 1'b0;
      ch_data  <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++)
        ch_wr[i] <= in_wr && (in_addr == 4'(i));
      unmapped <= in_wr && (in_addr >= CH_LIMIT);
      if (in_wr)
        ch_data <= in_data;
    end
  end

  // Search starts just after the last grant and wraps, so the first busy slot hit is the winner.
  always_comb begin
    found      = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    idx        = 0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      idx = 32'(last_grant) + k;
      if (idx >= CHANNELS)
        idx = idx - CHANNELS;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!found && (i == idx) && busy[i]) begin
          found      = 1'b1;
          grant_idx  = 4'(i);
          grant_data = slot_data[i];
        end
      end
    end
  end

  // A request against a full slot is dropped even when that slot is being granted this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (load && found && (grant_idx == 4'(i))) begin
          busy[i] <= 1'b0;
        end else if (rb_req[i] && !busy[i]) begin
          busy[i]      <= 1'b1;
          slot_data[i] <= rb_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_stb    <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      last_grant <= LAST_CH;
    end else if (load) begin
      out_stb <= found;
      if (found) begin
        out_data   <= grant_data;
        out_addr   <= grant_idx;
        last_grant <= grant_idx;
      end
    end
  end

`ifdef BUS_HUB_DROP_CNT_EN
  logic [7:0] drop_q;
  logic [4:0] drop_n;
  logic [8:0] drop_sum;

  always_comb begin
    drop_n = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      drop_n = drop_n + 5'(rb_req[i] & busy[i]);
    drop_sum = {1'b0, drop_q} + {4'b0, drop_n};
  end

  always_ff @(posedge clk) begin
    if (rst)
      drop_q <= '0;
    else if (drop_sum > 9'd255)
      drop_q <= '1;
    else
      drop_q <= drop_sum[7:0];
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_hub.sv
// Directed bench for bus_hub: write fan-out, readback latency, round-robin order, stall/drop and reset.
module tb_bus_hub;
  localparam int CH = 6;
  localparam int DW = 28;
  localparam int WW = 28;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_wr;
  logic [3:0]      in_addr;
  logic [WW-1:0]   in_data;
  logic [CH-1:0]   ch_wr;
  logic [WW-1:0]   ch_data;
  logic            unmapped;
  logic [CH-1:0]   rb_req;
  logic [CH*DW-1:0] rb_data;
  logic [CH-1:0]   rb_busy;
  logic [DW-1:0]   out_data;
  logic [3:0]      out_addr;
  logic            out_stb;
  logic            out_rdy;
  logic [7:0]      drop_cnt;

  int errors = 0;
  int checks = 0;

`ifdef BUS_HUB_DROP_CNT_EN
  localparam int EXP_DROPS = 1;
`else
  localparam int EXP_DROPS = 0;
`endif

  bus_hub #(.CHANNELS(CH), .DATA_W(DW), .WR_W(WW)) dut (
    .clk(clk), .rst(rst),
    .in_wr(in_wr), .in_addr(in_addr), .in_data(in_data),
    .ch_wr(ch_wr), .ch_data(ch_data), .unmapped(unmapped),
    .rb_req(rb_req), .rb_data(rb_data), .rb_busy(rb_busy),
    .out_data(out_data), .out_addr(out_addr), .out_stb(out_stb),
    .out_rdy(out_rdy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_wr = 1'b0; in_addr = '0; in_data = '0;
    rb_req = '0; rb_data = '0; out_rdy = 1'b1;
    tick(); tick();
    check("rst_ch_wr", 32'(ch_wr), 32'h0);
    check("rst_unmapped", 32'(unmapped), 32'h0);
    check("rst_busy", 32'(rb_busy), 32'h0);
    check("rst_out_stb", 32'(out_stb), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    rst = 1'b0;

    // Mapped write
    in_wr = 1'b1; in_addr = 4'd2; in_data = 28'h1234567;
    tick();
    in_wr = 1'b0;
    check("wr_ch_wr", 32'(ch_wr), 32'h04);
    check("wr_ch_data", 32'(ch_data), 32'h1234567);
    check("wr_unmapped", 32'(unmapped), 32'h0);
    tick();
    check("wr_ch_wr_off", 32'(ch_wr), 32'h0);
    check("wr_ch_data_hold", 32'(ch_data), 32'h1234567);

    // Unmapped write
    in_wr = 1'b1; in_addr = 4'd9; in_data = 28'h7654321;
    tick();
    in_wr = 1'b0;
    check("um_ch_wr", 32'(ch_wr), 32'h0);
    check("um_pulse", 32'(unmapped), 32'h1);
    tick();
    check("um_pulse_off", 32'(unmapped), 32'h0);

    // All channels at once, fresh after reset: order 0..5
    for (int i = 0; i < CH; i++) rb_data[i*DW +: DW] = 28'h0A00000 + 28'(i * 28'h11111);
    rb_req = '1;
    tick();
    rb_req = '0;
    check("all_busy", 32'(rb_busy), 32'h3F);
    check("all_stb_early", 32'(out_stb), 32'h0);
    for (int i = 0; i < CH; i++) begin
      tick();
      check("all_stb", 32'(out_stb), 32'h1);
      check("all_addr", 32'(out_addr), 32'(i));
      check("all_data", 32'(out_data), 32'h0A00000 + 32'(i * 32'h11111));
    end
    tick();
    check("all_drain", 32'(out_stb), 32'h0);
    check("all_busy_clr", 32'(rb_busy), 32'h0);

    // Isolated request on channel 3: latency 2
    rb_data[3*DW +: DW] = 28'hABCDEF0;
    rb_req = 6'b001000;
    tick();
    rb_req = '0;
    check("one_busy", 32'(rb_busy), 32'h08);
    check("one_stb_c1", 32'(out_stb), 32'h0);
    tick();
    check("one_stb_c2", 32'(out_stb), 32'h1);
    check("one_addr", 32'(out_addr), 32'h3);
    check("one_data", 32'(out_data), 32'hABCDEF0);
    check("one_busy_clr", 32'(rb_busy), 32'h0);
    tick();
    check("one_stb_off", 32'(out_stb), 32'h0);

    // Stall with channel 1; second request lands on the grant cycle and is dropped
    out_rdy = 1'b0;
    rb_data[1*DW +: DW] = 28'h5555555;
    rb_req = 6'b000010;
    tick();
    rb_data[1*DW +: DW] = 28'h2222222;
    tick();
    rb_req = '0;
    for (int i = 0; i < 10; i++) begin
      check("stall_stb", 32'(out_stb), 32'h1);
      check("stall_addr", 32'(out_addr), 32'h1);
      check("stall_data", 32'(out_data), 32'h5555555);
      tick();
    end
    check("stall_busy", 32'(rb_busy), 32'h0);
    check("stall_drop", 32'(drop_cnt), 32'(EXP_DROPS));
    out_rdy = 1'b1;
    tick();
    check("stall_release", 32'(out_stb), 32'h0);

    // Reset while a word is held and three slots are full
    out_rdy = 1'b0;
    rb_data[0*DW +: DW] = 28'h0000001;
    rb_req = 6'b000001;
    tick();
    rb_req = 6'b011100;
    tick();
    rb_req = '0;
    check("pre_rst_stb", 32'(out_stb), 32'h1);
    check("pre_rst_addr", 32'(out_addr), 32'h0);
    check("pre_rst_busy", 32'(rb_busy), 32'h1C);
    rst = 1'b1; rb_req = '1; in_wr = 1'b1; in_addr = 4'd0;
    tick();
    rst = 1'b0; rb_req = '0; in_wr = 1'b0;
    check("mid_rst_stb", 32'(out_stb), 32'h0);
    check("mid_rst_busy", 32'(rb_busy), 32'h0);
    check("mid_rst_ch_wr", 32'(ch_wr), 32'h0);
    check("mid_rst_drop", 32'(drop_cnt), 32'h0);

    // After reset channel 0 wins first
    out_rdy = 1'b1;
    rb_data[0*DW +: DW] = 28'h0C0FFEE;
    rb_data[3*DW +: DW] = 28'h0BEEF03;
    rb_req = 6'b001001;
    tick();
    rb_req = '0;
    tick();
    check("post_rst_addr0", 32'(out_addr), 32'h0);
    check("post_rst_data0", 32'(out_data), 32'h0C0FFEE);
    tick();
    check("post_rst_addr1", 32'(out_addr), 32'h3);
    check("post_rst_data1", 32'(out_data), 32'h0BEEF03);
    tick();
    check("post_rst_idle", 32'(out_stb), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
